fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the front-end fetch address and sequences word-aligned instruction memory reads that feed the unaligned-fetch prefetcher.
- Maintains the 3-bit fetch tag that the prefetcher uses to discard stale words.
- Arbitrates redirects with fixed priority: trap over jump over sequential.
- Holds fetch on pipeline hazards, on bus stalls and when the prefetcher reports a buffered half-word.

Parameters:
- START_ADDR, 32'h0000_0000, reset/boot PC; bit 0 ignored.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable_i  in  1  pipeline/bus advance; 0 freezes all state
- hazard_i  in  1  decode hazard; hold fetch address
- prefetched_i  in  1  prefetcher consumed a buffered compressed half-word; current word still needed
- jump_i  in  1  taken branch/jump from execute
- jump_target_i  in  32  jump destination
- trap_i  in  1  exception/interrupt/mret redirect
- trap_target_i  in  32  trap/return destination
- imem_req_o  out  1  instruction memory read strobe
- imem_addr_o  out  32  word-aligned read address, bits [1:0] = 0
- pc_o  out  32  PC of the word/half-word being requested, to prefetcher pc_i
- tag_o  out  3  current fetch tag, to prefetcher tag_i
- redirect_o  out  1  one-cycle pulse when a redirect is applied

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, imem_req_o = 0, tag_o = 0, redirect_o = 0
  - pc_o = START_ADDR with bit 0 cleared
  - imem_addr_o = START_ADDR with bits [1:0] cleared
- States:
  - IDLE: first enabled cycle after reset goes to BOOT.
  - BOOT: imem_req_o = 1 at START_ADDR; next enabled cycle goes to RUN.
  - RUN: imem_req_o = 1 and fetch advances.
  - HOLD: entered when hazard_i = 1; imem_req_o = 1 and imem_addr_o stable; returns to RUN when hazard_i = 0.
  - REDIRECT: one cycle, issues the word at the new target; then RUN.
- Sequential advance in RUN, per enabled cycle:
  - No hazard, prefetched_i = 0: imem_addr_o += 4 and pc_o = new imem_addr_o.
  - prefetched_i = 1: imem_addr_o and pc_o hold.
- Redirect target selection:
  - trap_i wins over jump_i; either wins over hazard_i and prefetched_i in the same cycle.
  - Target T: pc_o = T with bit 0 cleared; imem_addr_o = {T[31:2], 2'b00}.
  - tag_o increments modulo 8 (7 wraps to 0); redirect_o pulses for one cycle.
  - Latency: new address is visible the cycle after trap_i/jump_i is sampled with enable_i = 1.
- Redirect while enable_i = 0:
  - Target and source are latched into a pending register; a later trap overwrites a pending jump.
  - Applied on the first cycle enable_i = 1; that cycle counts as the redirect cycle.
- Any redirect in BOOT or HOLD goes straight to REDIRECT.
- Back-to-back redirects each increment the tag.
- enable_i = 0: all registers hold, including tag_o, state and imem_addr_o; imem_req_o keeps its value.
- Address arithmetic is 32-bit and wraps silently: 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-operation: immediate return to reset values; the pending redirect is cleared.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- When defined, adds three outputs, each reset to 0 and counting only when enable_i = 1:
  - redirect_count_o (32): counts applied redirects.
  - hold_count_o (32): counts cycles spent in HOLD.
  - bubble_count_o (32): counts prefetched_i hold cycles.
- Counters saturate at all-ones.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - fetch_state_e enum {IDLE, BOOT, RUN, HOLD, REDIRECT}
  - localparam FETCH_TAG_W = 3
  - localparam WORD_BYTES = 4
- Sub-module redirect_latch: pending-redirect register implementing the trap-over-jump priority, with valid/target/clear. It is reused by the data-side sequencer.

Test Plan:
- Reset with START_ADDR = 32'h100, then 4 enabled cycles -> BOOT addr 0x100, then RUN addrs 0x104, 0x108, 0x10C; tag_o = 0; imem_req_o = 1.
- hazard_i high 3 cycles at addr 0x108 -> addr holds 0x108 in HOLD; resumes at 0x10C the cycle after hazard_i drops.
- jump_i with target 0x202 and simultaneous hazard_i -> next cycle imem_addr_o = 0x200, pc_o = 0x202, tag_o += 1, redirect_o pulse.
- trap_i (target 0x80) and jump_i (target 0x400) in the same cycle -> addr 0x80; tag increments once.
- 8 consecutive redirects starting from tag 7 -> tag sequence 0, 1, …, 7; wrap verified.
- jump_i to 0x300 while enable_i = 0, then trap_i to 0x40 still disabled, then enable -> single redirect to 0x40; pending latch cleared; reset mid-hold -> all outputs return to reset values.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-sequencer types, widths and address helpers.
// Also used by the data-side sequencer through redirect_latch.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        RUN,
        HOLD,
        REDIRECT
    } fetch_state_e;

    localparam int          FETCH_TAG_W = 3;
    localparam logic [31:0] WORD_BYTES  = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] half_align(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_redirect_latch.sv
// Pending-redirect register: merges live trap/jump requests with a held one, trap wins over jump.
// Combinational view (vld_o/target_o) includes this cycle's requests; clear_i drops the held entry.
module redirect_latch
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_i,
    input  logic [31:0] trap_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        clear_i,
    output logic        vld_o,
    output logic [31:0] target_o
);

    logic        pend_vld_q,  pend_vld_d;
    logic        pend_trap_q, pend_trap_d;
    logic [31:0] pend_tgt_q,  pend_tgt_d;

    // A held trap outranks a new jump; a new trap outranks everything.
    always_comb begin
        vld_o    = trap_i | jump_i | pend_vld_q;
        target_o = pend_tgt_q;
        if (trap_i) begin
            target_o = trap_target_i;
        end else if (pend_vld_q && pend_trap_q) begin
            target_o = pend_tgt_q;
        end else if (jump_i) begin
            target_o = jump_target_i;
        end

        pend_vld_d  = pend_vld_q;
        pend_trap_d = pend_trap_q;
        pend_tgt_d  = pend_tgt_q;
        if (clear_i) begin
            pend_vld_d  = 1'b0;
            pend_trap_d = 1'b0;
        end else if (vld_o) begin
            pend_vld_d  = 1'b1;
            pend_trap_d = trap_i | (pend_vld_q & pend_trap_q);
            pend_tgt_d  = target_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_tgt_q  <= 32'd0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_trap_q <= pend_trap_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch address sequencer with trap > jump > sequential redirect priority and 3-bit fetch tag.
// Outputs are registered (redirect visible one cycle after sampling); enable_i=0 freezes state. FETCH_SEQ_PERF_EN adds counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic                   hazard_i,
    input  logic                   prefetched_i,
    input  logic                   jump_i,
    input  logic [31:0]            jump_target_i,
    input  logic                   trap_i,
    input  logic [31:0]            trap_target_i,
    output logic                   imem_req_o,
    output logic [31:0]            imem_addr_o,
    output logic [31:0]            pc_o,
    output logic [FETCH_TAG_W-1:0] tag_o,
    output logic                   redirect_o
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]            redirect_count_o,
    output logic [31:0]            hold_count_o,
    output logic [31:0]            bubble_count_o
`endif
);

    fetch_state_e           state_q, state_d;
    logic                   req_q, req_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            pc_q, pc_d;
    logic [FETCH_TAG_W-1:0] tag_q, tag_d;
    logic                   redir_q, redir_d;

    logic        rl_vld;
    logic [31:0] rl_target;
    logic        apply_redir;
    logic        bubble;

    // Redirects seen in IDLE stay pending until the boot word has been issued.
    assign apply_redir = enable_i & (state_q != IDLE) & rl_vld;
    assign bubble      = enable_i & (state_q != IDLE) & ~rl_vld & ~hazard_i & prefetched_i;

    redirect_latch u_redirect_latch (
        .clk           (clk),
        .rst_n         (reset_n),
        .trap_i        (trap_i),
        .trap_target_i (trap_target_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .clear_i       (apply_redir),
        .vld_o         (rl_vld),
        .target_o      (rl_target)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        redir_d = redir_q;
        if (enable_i) begin
            redir_d = 1'b0;
            if (state_q == IDLE) begin
                state_d = BOOT;
                req_d   = 1'b1;
            end else if (rl_vld) begin
                state_d = REDIRECT;
                addr_d  = word_align(rl_target);
                pc_d    = half_align(rl_target);
                tag_d   = tag_q + 3'd1;
                redir_d = 1'b1;
            end else if (hazard_i) begin
                state_d = HOLD;
            end else if (prefetched_i) begin
                state_d = RUN;
            end else begin
                state_d = RUN;
                addr_d  = addr_q + WORD_BYTES;
                pc_d    = addr_q + WORD_BYTES;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= word_align(START_ADDR);
            pc_q    <= half_align(START_ADDR);
            tag_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            redir_q <= redir_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign pc_o        = pc_q;
    assign tag_o       = tag_q;
    assign redirect_o  = redir_q;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic [31:0] hold_cnt_q,  hold_cnt_d;
    logic [31:0] bub_cnt_q,   bub_cnt_d;

    always_comb begin
        redir_cnt_d = apply_redir ? sat_inc(redir_cnt_q) : redir_cnt_q;
        hold_cnt_d  = (enable_i && state_q == HOLD) ? sat_inc(hold_cnt_q) : hold_cnt_q;
        bub_cnt_d   = bubble ? sat_inc(bub_cnt_q) : bub_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redir_cnt_q <= 32'd0;
            hold_cnt_q  <= 32'd0;
            bub_cnt_q   <= 32'd0;
        end else begin
            redir_cnt_q <= redir_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            bub_cnt_q   <= bub_cnt_d;
        end
    end

    assign redirect_count_o = redir_cnt_q;
    assign hold_count_o     = hold_cnt_q;
    assign bubble_count_o   = bub_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] START = 32'h0000_0100;

    logic        clk;
    logic        reset_n;
    logic        enable_i, hazard_i, prefetched_i, jump_i, trap_i;
    logic [31:0] jump_target_i, trap_target_i;
    logic        imem_req_o, redirect_o;
    logic [31:0] imem_addr_o, pc_o;
    logic [2:0]  tag_o;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] redirect_count_o, hold_count_o, bubble_count_o;
`endif

    fetch_sequencer #(.START_ADDR(START)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable_i      (enable_i),
        .hazard_i      (hazard_i),
        .prefetched_i  (prefetched_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .trap_i        (trap_i),
        .trap_target_i (trap_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .pc_o          (pc_o),
        .tag_o         (tag_o),
        .redirect_o    (redirect_o)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .redirect_count_o (redirect_count_o),
        .hold_count_o     (hold_count_o),
        .bubble_count_o   (bubble_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Behavioural model: booted flag, registered outputs, one pending redirect slot.
    bit          m_booted;
    bit          m_req, m_redir;
    logic [31:0] m_addr, m_pc;
    int          m_tag;
    bit          p_has, p_trap;
    logic [31:0] p_tgt;

    task automatic model_reset();
        m_booted = 0; m_req = 0; m_redir = 0;
        m_addr = START & 32'hFFFF_FFFC;
        m_pc   = START & 32'hFFFF_FFFE;
        m_tag  = 0;
        p_has  = 0; p_trap = 0; p_tgt = 0;
    endtask

    task automatic model_step();
        bit          want;
        logic [31:0] tgt;
        want = trap_i || jump_i || p_has;
        if (trap_i)              tgt = trap_target_i;
        else if (p_has && p_trap) tgt = p_tgt;
        else if (jump_i)         tgt = jump_target_i;
        else                     tgt = p_tgt;
        if (!enable_i) return;
        if (!m_booted) begin
            m_booted = 1; m_req = 1; m_redir = 0;
            if (want) begin
                p_trap = trap_i || (p_has && p_trap);
                p_has = 1; p_tgt = tgt;
            end
        end else if (want) begin
            p_has = 0; p_trap = 0;
            m_addr  = tgt & 32'hFFFF_FFFC;
            m_pc    = tgt & 32'hFFFF_FFFE;
            m_tag   = (m_tag + 1) % 8;
            m_redir = 1;
        end else begin
            m_redir = 0;
            if (!hazard_i && !prefetched_i) begin
                m_addr = m_addr + 32'd4;
                m_pc   = m_addr;
            end
        end
    endtask

    // Disabled cycles only update the pending slot.
    task automatic model_pend_disabled();
        if (trap_i) begin
            p_has = 1; p_trap = 1; p_tgt = trap_target_i;
        end else if (jump_i && !(p_has && p_trap)) begin
            p_has = 1; p_trap = 0; p_tgt = jump_target_i;
        end
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".req"},   {31'd0, imem_req_o}, {31'd0, m_req});
        chk({ctx, ".addr"},  imem_addr_o, m_addr);
        chk({ctx, ".pc"},    pc_o, m_pc);
        chk({ctx, ".tag"},   {29'd0, tag_o}, m_tag[31:0]);
        chk({ctx, ".redir"}, {31'd0, redirect_o}, {31'd0, m_redir});
    endtask

    task automatic cycle(input bit en, input bit haz, input bit pref,
                         input bit jmp, input logic [31:0] jt,
                         input bit trp, input logic [31:0] tt, input string ctx);
        @(negedge clk);
        enable_i = en; hazard_i = haz; prefetched_i = pref;
        jump_i = jmp; jump_target_i = jt; trap_i = trp; trap_target_i = tt;
        @(posedge clk);
        if (en) model_step();
        else    model_pend_disabled();
        #1;
        check_model(ctx);
    endtask

    task automatic plain(input string ctx);
        cycle(1, 0, 0, 0, 0, 0, 0, ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst.req",   {31'd0, imem_req_o}, 32'd0);
        chk("rst.addr",  imem_addr_o, 32'h100);
        chk("rst.pc",    pc_o, 32'h100);
        chk("rst.tag",   {29'd0, tag_o}, 32'd0);
        chk("rst.redir", {31'd0, redirect_o}, 32'd0);
        @(negedge clk);
        enable_i = 0; hazard_i = 0; prefetched_i = 0; jump_i = 0; trap_i = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable_i = 0; hazard_i = 0; prefetched_i = 0;
        jump_i = 0; trap_i = 0; jump_target_i = 0; trap_target_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Boot and sequential run
        plain("boot");
        chk("boot.addr_0x100", imem_addr_o, 32'h100);
        plain("run1");
        plain("run2");
        plain("run3");
        chk("run.addr_0x10c", imem_addr_o, 32'h10C);
        chk("run.req", {31'd0, imem_req_o}, 32'd1);

        // Hazard hold then resume
        repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, "hazard");
        chk("hold.addr", imem_addr_o, 32'h10C);
        plain("resume");
        chk("resume.addr", imem_addr_o, 32'h110);

        // Prefetched half-word holds
        cycle(1, 0, 1, 0, 0, 0, 0, "pref");
        chk("pref.addr", imem_addr_o, 32'h110);

        // Jump with simultaneous hazard
        cycle(1, 1, 0, 1, 32'h202, 0, 0, "jump_haz");
        chk("jump.addr", imem_addr_o, 32'h200);
        chk("jump.pc",   pc_o, 32'h202);
        chk("jump.tag",  {29'd0, tag_o}, 32'd1);
        chk("jump.redir", {31'd0, redirect_o}, 32'd1);
        plain("after_jump");
        chk("after_jump.addr", imem_addr_o, 32'h204);

        // Trap beats jump
        cycle(1, 0, 0, 1, 32'h400, 1, 32'h80, "trap_jump");
        chk("trapjump.addr", imem_addr_o, 32'h80);
        chk("trapjump.tag",  {29'd0, tag_o}, 32'd2);

        // Advance tag to 7 then 8 back-to-back redirects wrap through 0..7
        repeat (5) cycle(1, 0, 0, 1, 32'h1000, 0, 0, "to7");
        chk("tag7", {29'd0, tag_o}, 32'd7);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 1, 1, 32'h2000 + 32'(i * 8), 0, 0, "b2b");
            chk("b2b.tag", {29'd0, tag_o}, 32'(i));
        end

        // Redirects while disabled: trap overwrites pending jump
        cycle(0, 0, 0, 1, 32'h300, 0, 0, "dis_jump");
        cycle(0, 0, 0, 0, 0, 1, 32'h40, "dis_trap");
        chk("dis.addr_frozen", imem_addr_o, 32'h2038);
        plain("dis_apply");
        chk("dis_apply.addr", imem_addr_o, 32'h40);
        chk("dis_apply.tag",  {29'd0, tag_o}, 32'd0);
        plain("dis_cleared");
        chk("dis_cleared.addr", imem_addr_o, 32'h44);
        chk("dis_cleared.redir", {31'd0, redirect_o}, 32'd0);

        // Address wrap
        cycle(1, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, "wrap_jump");
        plain("wrap");
        chk("wrap.addr", imem_addr_o, 32'h0);

        // Reset mid-hold with a pending redirect
        cycle(1, 1, 0, 0, 0, 0, 0, "pre_rst_hold");
        cycle(0, 1, 0, 1, 32'h5000, 0, 0, "pre_rst_pend");
        do_reset();
        plain("post_rst_boot");
        plain("post_rst_run");
        chk("post_rst.addr", imem_addr_o, 32'h104);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit          en, haz, pref, jmp, trp;
            logic [31:0] jt, tt;
            en   = ($urandom_range(0, 99) < 80);
            haz  = ($urandom_range(0, 99) < 15);
            pref = ($urandom_range(0, 99) < 15);
            jmp  = ($urandom_range(0, 99) < 10);
            trp  = ($urandom_range(0, 99) < 5);
            jt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tt   = $urandom;
            cycle(en, haz, pref, jmp, jt, trp, tt, "rand");
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
